irq_sequencer: RTL and testbench

- Interrupt and reset sequencer for cpu6502; replaces the fixed vector select (BRK vector FE, reset vector FC) inside the core.
- Detects NMI edges and IRQ levels, and decides at each opcode-fetch boundary whether to substitute a forced BRK (opcode 00).
- Selects the vector low byte, the B bit value for the pushed P, PC-increment suppression and write inhibit for the forced sequence.
- Sits between external interrupt pins and the core's IR select, ADL vector mux and DB_P path.

---
 rtl/irq_sequencer_if.sv | 25 ++
 rtl/irq_sequencer.sv | 152 +++++++++++++++
 tb/tb_irq_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_sequencer_if.sv
// Core-side connection of the interrupt/reset sequencer: opcode-fetch
// timing and flags from the core, BRK forcing and vector control back to it.
interface irq_sequencer_if;
  logic       i_flag;
  logic       sync;
  logic       sw_brk;
  logic       vec_fetch;
  logic       force_brk;
  logic       pc_hold;
  logic       write_inhibit;
  logic       b_flag;
  logic [7:0] vector_lo;
  logic       int_active;

  // The core drives fetch timing and flags, and consumes the sequencer controls.
  modport master (
    output i_flag, sync, sw_brk, vec_fetch,
    input  force_brk, pc_hold, write_inhibit, b_flag, vector_lo, int_active
  );

  modport slave (
    input  i_flag, sync, sw_brk, vec_fetch,
    output force_brk, pc_hold, write_inhibit, b_flag, vector_lo, int_active
  );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt and reset sequencer for cpu6502. Decides at each opcode fetch
// whether to force a BRK, and steers vector, B bit, PC hold and write gating
// for the reset, NMI, IRQ and software BRK sequences.
module irq_sequencer #(
  parameter logic [7:0] NMI_VEC  = 8'hFA,
  parameter logic [7:0] RST_VEC  = 8'hFC,
  parameter logic [7:0] IRQ_VEC  = 8'hFE,
  parameter int         IRQ_SYNC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            nmi,
  input  logic            irq,
  irq_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    SEQ = 2'd1,
    RST = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                nmi_prev;
  logic                nmi_pend;
  logic                nmi_pend_nx;
  logic                nmi_edge;
  logic [IRQ_SYNC-1:0] irq_ff;
  logic                irq_ok;
  logic                take;
  logic                pc_hold;
  logic                pc_hold_nx;
  logic                write_inhibit;
  logic                write_inhibit_nx;
  logic                b_flag;
  logic                b_flag_nx;
  logic                int_active;
  logic                int_active_nx;
  logic [7:0]          vector_lo;
  logic [7:0]          vector_lo_nx;

  assign nmi_edge = nmi & ~nmi_prev;
  assign irq_ok   = irq_ff[IRQ_SYNC-1] & ~bus.i_flag;
  assign take     = bus.sync & (state == RUN) & (nmi_pend | irq_ok);

  // During the reset sequence every fetch is replaced, so the core walks the BRK microcode.
  assign bus.force_brk     = take | (bus.sync & (state == RST));
  assign bus.pc_hold       = pc_hold;
  assign bus.write_inhibit = write_inhibit;
  assign bus.b_flag        = b_flag;
  assign bus.vector_lo     = vector_lo;
  assign bus.int_active    = int_active;

  // NMI edge history and the IRQ synchronizer chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_prev <= 1'b0;
      irq_ff   <= '0;
    end else begin
      nmi_prev  <= nmi;
      irq_ff[0] <= irq;
      for (int i = 1; i < IRQ_SYNC; i++) begin
        irq_ff[i] <= irq_ff[i-1];
      end
    end
  end

  // State, NMI pending flag and all registered core controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RST;
      nmi_pend      <= 1'b0;
      pc_hold       <= 1'b1;
      write_inhibit <= 1'b1;
      b_flag        <= 1'b0;
      vector_lo     <= RST_VEC;
      int_active    <= 1'b1;
    end else begin
      state         <= state_nx;
      nmi_pend      <= nmi_pend_nx;
      pc_hold       <= pc_hold_nx;
      write_inhibit <= write_inhibit_nx;
      b_flag        <= b_flag_nx;
      vector_lo     <= vector_lo_nx;
      int_active    <= int_active_nx;
    end
  end

  // Sequence transitions; a new NMI edge always wins over a same-cycle clear of the pend flag.
  always_comb begin
    state_nx         = state;
    nmi_pend_nx      = nmi_pend;
    pc_hold_nx       = pc_hold;
    write_inhibit_nx = write_inhibit;
    b_flag_nx        = b_flag;
    vector_lo_nx     = vector_lo;
    int_active_nx    = int_active;

    case (state)
      RUN: begin
        if (take) begin
          state_nx      = SEQ;
          pc_hold_nx    = 1'b1;
          b_flag_nx     = 1'b0;
          int_active_nx = 1'b1;
          if (nmi_pend) begin
            vector_lo_nx = NMI_VEC;
            nmi_pend_nx  = 1'b0;
          end else begin
            vector_lo_nx = IRQ_VEC;
          end
        end else if (bus.sync && bus.sw_brk) begin
          state_nx     = SEQ;
          pc_hold_nx   = 1'b0;
          b_flag_nx    = 1'b1;
          vector_lo_nx = IRQ_VEC;
        end
      end
      SEQ: begin
        if (bus.vec_fetch) begin
          state_nx      = RUN;
          pc_hold_nx    = 1'b0;
          int_active_nx = 1'b0;
          b_flag_nx     = 1'b1;
          vector_lo_nx  = IRQ_VEC;
        end else if (nmi_pend && (vector_lo == IRQ_VEC)) begin
          vector_lo_nx = NMI_VEC;
          nmi_pend_nx  = 1'b0;
        end
      end
      RST: begin
        if (bus.vec_fetch) begin
          state_nx         = RUN;
          write_inhibit_nx = 1'b0;
          pc_hold_nx       = 1'b0;
          int_active_nx    = 1'b0;
          b_flag_nx        = 1'b1;
          vector_lo_nx     = IRQ_VEC;
        end
      end
      default: begin
        state_nx = RST;
      end
    endcase

    if (nmi_edge) begin
      nmi_pend_nx = 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: directed scenarios with literal
// expectations, then randomized pins checked every cycle against a model.
module tb_irq_sequencer;

  localparam int IRQ_SYNC = 2;
  localparam logic [7:0] V_NMI = 8'hFA;
  localparam logic [7:0] V_RST = 8'hFC;
  localparam logic [7:0] V_IRQ = 8'hFE;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic nmi   = 1'b0;
  logic irq   = 1'b0;

  int checks = 0;
  int errors = 0;

  irq_sequencer_if bus();

  irq_sequencer #(
    .NMI_VEC (V_NMI),
    .RST_VEC (V_RST),
    .IRQ_VEC (V_IRQ),
    .IRQ_SYNC(IRQ_SYNC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .nmi  (nmi),
    .irq  (irq),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: what the sequencer is doing, plus the values its outputs must hold.
  bit       m_boot;
  bit       m_busy;
  bit       m_pend;
  bit       m_prev;
  bit       m_hist [3];
  bit       m_ph;
  bit       m_wi;
  bit       m_b;
  bit       m_ia;
  bit [7:0] m_vec;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic void modelReset();
    m_boot = 1'b1;
    m_busy = 1'b0;
    m_pend = 1'b0;
    m_prev = 1'b0;
    for (int i = 0; i < 3; i++) m_hist[i] = 1'b0;
    m_ph  = 1'b1;
    m_wi  = 1'b1;
    m_b   = 1'b0;
    m_ia  = 1'b1;
    m_vec = V_RST;
  endfunction

  initial modelReset();

  // Compare DUT against the model mid-cycle, then advance the model to the next clock edge.
  always @(negedge clk) begin
    bit irq_seen;
    bit take_now;
    bit exp_force;
    bit rise;
    if (reset) modelReset();
    irq_seen  = m_hist[IRQ_SYNC-1];
    take_now  = !m_boot && !m_busy && bus.sync && (m_pend || (irq_seen && !bus.i_flag));
    exp_force = m_boot ? bus.sync : take_now;
    checkOutput("force_brk", bus.force_brk, exp_force);
    checkOutput("pc_hold", bus.pc_hold, m_ph);
    checkOutput("write_inhibit", bus.write_inhibit, m_wi);
    checkOutput("b_flag", bus.b_flag, m_b);
    checkOutput("vector_lo", bus.vector_lo, m_vec);
    checkOutput("int_active", bus.int_active, m_ia);
    if (!reset) begin
      rise = nmi && !m_prev;
      if (m_boot) begin
        if (bus.vec_fetch) begin
          m_boot = 1'b0; m_wi = 1'b0; m_ph = 1'b0; m_ia = 1'b0; m_b = 1'b1; m_vec = V_IRQ;
        end
      end else if (m_busy) begin
        if (bus.vec_fetch) begin
          m_busy = 1'b0; m_ph = 1'b0; m_ia = 1'b0; m_b = 1'b1; m_vec = V_IRQ;
        end else if (m_pend && m_vec == V_IRQ) begin
          m_vec = V_NMI; m_pend = 1'b0;
        end
      end else if (take_now) begin
        m_busy = 1'b1; m_ph = 1'b1; m_b = 1'b0; m_ia = 1'b1;
        m_vec  = m_pend ? V_NMI : V_IRQ;
        m_pend = 1'b0;
      end else if (bus.sync && bus.sw_brk) begin
        m_busy = 1'b1; m_ph = 1'b0; m_b = 1'b1; m_vec = V_IRQ;
      end
      if (rise) m_pend = 1'b1;
      m_prev    = nmi;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = irq;
    end
  end

  // Drive one cycle of pins just after the rising edge.
  task automatic applyStimulus(input bit rst, input bit s, input bit sb, input bit vf,
                               input bit ifl, input bit n, input bit i);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.sync      = s;
    bus.sw_brk    = sb;
    bus.vec_fetch = vf;
    bus.i_flag    = ifl;
    nmi           = n;
    irq           = i;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Directed scenarios with hand-derived values, then random traffic.
  initial begin
    bus.sync = 1'b0; bus.sw_brk = 1'b0; bus.vec_fetch = 1'b0; bus.i_flag = 1'b0;

    // Reset values and the post-reset sequence.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst vector_lo", bus.vector_lo, 8'hFC);
    checkOutput("rst write_inhibit", bus.write_inhibit, 1'b1);
    checkOutput("rst pc_hold", bus.pc_hold, 1'b1);
    checkOutput("rst int_active", bus.int_active, 1'b1);
    checkOutput("rst b_flag", bus.b_flag, 1'b0);
    idle(1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("boot force_brk", bus.force_brk, 1'b1);
    idle(2);
    checkOutput("boot write_inhibit", bus.write_inhibit, 1'b1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    checkOutput("boot exit write_inhibit", bus.write_inhibit, 1'b0);
    checkOutput("boot exit vector_lo", bus.vector_lo, 8'hFE);
    checkOutput("boot exit int_active", bus.int_active, 1'b0);

    // IRQ taken when enabled, ignored when masked.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput("irq force_brk", bus.force_brk, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("irq vector_lo", bus.vector_lo, 8'hFE);
    checkOutput("irq b_flag", bus.b_flag, 1'b0);
    checkOutput("irq pc_hold", bus.pc_hold, 1'b1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    checkOutput("irq exit int_active", bus.int_active, 1'b0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 1, 0, 1);
    checkOutput("masked irq force_brk", bus.force_brk, 1'b0);
    idle(3);

    // NMI beats a concurrent IRQ, then the IRQ follows.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput("nmi force_brk", bus.force_brk, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("nmi vector_lo", bus.vector_lo, 8'hFA);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput("irq after nmi force_brk", bus.force_brk, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("irq after nmi vector_lo", bus.vector_lo, 8'hFE);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idle(3);

    // Software BRK hijacked by an NMI edge before the vector fetch.
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("sw brk force_brk", bus.force_brk, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("sw brk vector_lo", bus.vector_lo, 8'hFE);
    checkOutput("sw brk b_flag", bus.b_flag, 1'b1);
    checkOutput("sw brk pc_hold", bus.pc_hold, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("hijack vector_lo", bus.vector_lo, 8'hFA);
    checkOutput("hijack b_flag", bus.b_flag, 1'b1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("hijack cleared pend", bus.force_brk, 1'b0);
    idle(2);

    // NMI edge in the vec_fetch cycle stays pending for the next fetch.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput("irq2 force_brk", bus.force_brk, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    checkOutput("late nmi vector_lo", bus.vector_lo, 8'hFE);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("late nmi exit vector_lo", bus.vector_lo, 8'hFE);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("late nmi force_brk", bus.force_brk, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("late nmi taken vector_lo", bus.vector_lo, 8'hFA);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idle(2);

    // Reset mid-sequence with an NMI pending discards it.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("mid rst vector_lo", bus.vector_lo, 8'hFC);
    checkOutput("mid rst write_inhibit", bus.write_inhibit, 1'b1);
    checkOutput("mid rst int_active", bus.int_active, 1'b1);
    idle(1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("mid rst boot force_brk", bus.force_brk, 1'b1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("discarded nmi force_brk", bus.force_brk, 1'b0);
    idle(2);

    // Random pin activity; the negedge compare process checks every cycle.
    begin
      bit ifl = 0;
      bit iq  = 0;
      for (int c = 0; c < 5000; c++) begin
        if ($urandom_range(0, 15) == 0) ifl = ~ifl;
        if ($urandom_range(0, 9) == 0) iq = ~iq;
        applyStimulus($urandom_range(0, 299) == 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 0,
                      $urandom_range(0, 7) == 0,
                      ifl,
                      $urandom_range(0, 7) == 0,
                      iq);
      end
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
